// File: rtl/ecg_classifier_top.sv
// ecg_classifier_top
// Captures a 15-sample ECG beat on start, scans it one sample per cycle to
// find peak, trough and peak position, then applies a fixed priority rule
// set and registers a one-hot class code (N/S/V/Q) on classifier.
module ecg_classifier_top #(
    parameter int unsigned RANGE_MIN = 4,   // range below this -> Q
    parameter int unsigned V_RANGE   = 64,  // range at or above this -> V
    parameter int unsigned EARLY_IDX = 3    // peak index below this -> S
) (
    input  logic       clk,
    input  logic       rst,                 // asynchronous, active-low
    input  logic       start,
    input  logic [7:0] ecg_input [0:14],
    output logic [3:0] classifier
);

    localparam int unsigned N_SAMPLES = 15;
    localparam logic [3:0]  LAST_IDX  = 4'(N_SAMPLES - 1);

    // Thresholds narrowed to the datapath widths so all compares are same-width.
    localparam logic [7:0]  RANGE_MIN_B = 8'(RANGE_MIN);
    localparam logic [7:0]  V_RANGE_B   = 8'(V_RANGE);
    localparam logic [3:0]  EARLY_IDX_B = 4'(EARLY_IDX);

    // One-hot class codes.
    localparam logic [3:0]  CLS_N = 4'b0001;
    localparam logic [3:0]  CLS_S = 4'b0010;
    localparam logic [3:0]  CLS_V = 4'b0100;
    localparam logic [3:0]  CLS_Q = 4'b1000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCAN     = 2'd1,
        CLASSIFY = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [3:0] idx_reg;
    logic [3:0] idx_next;
    logic [7:0] max_reg;
    logic [7:0] max_next;
    logic [7:0] min_reg;
    logic [7:0] min_next;
    logic [3:0] max_idx_reg;
    logic [3:0] max_idx_next;
    logic [3:0] classifier_reg;
    logic [3:0] classifier_next;

    logic       latch_en;
    logic [7:0] buf_tap [0:N_SAMPLES-1];
    logic [7:0] cur_sample;
    logic [7:0] range_val;
    logic [3:0] class_code;

    // Sample buffer: one register per sample, loaded only at the accepting
    // start edge so later input changes cannot disturb a run in progress.
    genvar gi;
    generate
        for (gi = 0; gi < N_SAMPLES; gi++) begin : g_buf
            logic [7:0] sample_reg;

            // Capture sample gi when a run is accepted.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sample_reg <= 8'd0;
                end else if (latch_en) begin
                    sample_reg <= ecg_input[gi];
                end
            end

            assign buf_tap[gi] = sample_reg;
        end
    endgenerate

    // Sample currently being scanned; idx_reg never exceeds LAST_IDX.
    assign cur_sample = buf_tap[idx_reg];

    // Peak-to-trough range and rule-based class selection (highest priority first).
    always_comb begin
        range_val  = max_reg - min_reg;
        class_code = CLS_N;
        if (range_val < RANGE_MIN_B) begin
            class_code = CLS_Q;
        end else if (range_val >= V_RANGE_B) begin
            class_code = CLS_V;
        end else if (max_idx_reg < EARLY_IDX_B) begin
            class_code = CLS_S;
        end else begin
            class_code = CLS_N;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_next      = state;
        idx_next        = idx_reg;
        max_next        = max_reg;
        min_next        = min_reg;
        max_idx_next    = max_idx_reg;
        classifier_next = classifier_reg;
        latch_en        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    latch_en     = 1'b1;
                    idx_next     = 4'd0;
                    max_next     = 8'd0;
                    min_next     = 8'hFF;
                    max_idx_next = 4'd0;
                    state_next   = SCAN;
                end
            end

            SCAN: begin
                // Strict greater-than keeps the first occurrence of a tied peak.
                if (cur_sample > max_reg) begin
                    max_next     = cur_sample;
                    max_idx_next = idx_reg;
                end
                if (cur_sample < min_reg) begin
                    min_next = cur_sample;
                end
                if (idx_reg == LAST_IDX) begin
                    state_next = CLASSIFY;
                end else begin
                    idx_next = idx_reg + 4'd1;
                end
            end

            CLASSIFY: begin
                classifier_next = class_code;
                state_next      = DONE;
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Scan datapath and result registers; reset aborts any run without a result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_reg        <= 4'd0;
            max_reg        <= 8'd0;
            min_reg        <= 8'd0;
            max_idx_reg    <= 4'd0;
            classifier_reg <= 4'd0;
        end else begin
            idx_reg        <= idx_next;
            max_reg        <= max_next;
            min_reg        <= min_next;
            max_idx_reg    <= max_idx_next;
            classifier_reg <= classifier_next;
        end
    end

    assign classifier = classifier_reg;

endmodule

// File: tb/tb_ecg_classifier_top.sv
// tb_ecg_classifier_top
// Directed bench for ecg_classifier_top with hand-computed expected results.
module tb_ecg_classifier_top;

    localparam int ST_IDLE     = 0;
    localparam int ST_SCAN     = 1;
    localparam int ST_CLASSIFY = 2;
    localparam int ST_DONE     = 3;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] ecg_input [0:14];
    logic [3:0] classifier;

    logic [7:0] beat [0:14];
    int         total;
    int         bad;
    int         prev_cls;
    int         tbl [11][7];

    ecg_classifier_top dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ecg_input  (ecg_input),
        .classifier (classifier)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic build_beat(input int base, input int pidx, input int pval);
        for (int k = 0; k < 15; k++) beat[k] = 8'(base);
        beat[pidx] = 8'(pval);
    endtask

    // One full run from IDLE: start edge E, checks at E+1, E+15, E+16, E+17.
    task automatic run_beat(input string tag, input int exp_cls, input int exp_max,
                            input int exp_idx, input int exp_min, input bit scramble);
        @(negedge clk);
        for (int k = 0; k < 15; k++) ecg_input[k] = beat[k];
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "_scan_state"}, int'(dut.state), ST_SCAN);
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
            if (scramble && k == 2) begin
                for (int j = 0; j < 15; j++) ecg_input[j] = (j % 2 == 1) ? 8'd255 : 8'd0;
            end
        end
        check({tag, "_classify_state"}, int'(dut.state), ST_CLASSIFY);
        check({tag, "_held_cls"}, int'(classifier), prev_cls);
        check({tag, "_max"}, int'(dut.max_reg), exp_max);
        check({tag, "_max_idx"}, int'(dut.max_idx_reg), exp_idx);
        check({tag, "_min"}, int'(dut.min_reg), exp_min);
        @(posedge clk);
        #1;
        check({tag, "_cls"}, int'(classifier), exp_cls);
        check({tag, "_done_state"}, int'(dut.state), ST_DONE);
        @(posedge clk);
        #1;
        check({tag, "_idle_state"}, int'(dut.state), ST_IDLE);
        prev_cls = exp_cls;
        $display("beat %s: classifier=%b expected=%b", tag, classifier, 4'(exp_cls));
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        prev_cls = 0;
        rst      = 1'b0;
        start    = 1'b0;
        for (int k = 0; k < 15; k++) ecg_input[k] = 8'd0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_cls", int'(classifier), 0);
        check("reset_state", int'(dut.state), ST_IDLE);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("idle_cls", int'(classifier), 0);
        check("idle_state", int'(dut.state), ST_IDLE);
        $display("reset: classifier=%b state=%0d", classifier, int'(dut.state));

        // Early-peak beat from the worked example.
        beat = '{8'd16, 8'd15, 8'd7, 8'd3, 8'd0, 8'd3, 8'd5, 8'd6,
                 8'd6, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
        run_beat("early", 2, 16, 0, 0, 1'b0);

        // Single-peak table: base, peak index, peak value, class, max, max_idx, min.
        tbl = '{
            '{50, 7,  50, 8,  50, 0, 50},   // flat, range 0
            '{10, 7, 200, 4, 200, 7, 10},   // large, range 190
            '{10, 7,  40, 1,  40, 7, 10},   // normal, range 30
            '{10, 7,  13, 8,  13, 7, 10},   // range 3, just below RANGE_MIN
            '{10, 7,  14, 1,  14, 7, 10},   // range 4, exactly RANGE_MIN
            '{10, 7,  74, 4,  74, 7, 10},   // range 64, exactly V_RANGE
            '{10, 7,  73, 1,  73, 7, 10},   // range 63, just below V_RANGE
            '{10, 3,  40, 1,  40, 3, 10},   // peak at EARLY_IDX
            '{10, 2,  40, 2,  40, 2, 10},   // peak just before EARLY_IDX
            '{ 0, 14, 30, 1,  30, 14, 0},   // peak at last sample
            '{10, 0,  40, 2,  40, 0, 10}    // peak at first sample
        };
        for (int r = 0; r < 11; r++) begin
            build_beat(tbl[r][0], tbl[r][1], tbl[r][2]);
            run_beat($sformatf("tbl%0d", r), tbl[r][3], tbl[r][4], tbl[r][5], tbl[r][6], 1'b0);
        end

        // Two equal peaks: first occurrence wins.
        build_beat(10, 7, 40);
        beat[2] = 8'd40;
        run_beat("tie", 2, 40, 2, 10, 1'b0);

        // Inputs scrambled during SCAN: result must follow the latched beat.
        build_beat(10, 7, 40);
        run_beat("scramble", 1, 40, 7, 10, 1'b1);

        // Reset mid-run at E+8 aborts and clears the result.
        build_beat(10, 7, 200);
        @(negedge clk);
        for (int k = 0; k < 15; k++) ecg_input[k] = beat[k];
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("midrst_pre_state", int'(dut.state), ST_SCAN);
        rst = 1'b0;
        #1;
        check("midrst_cls", int'(classifier), 0);
        check("midrst_state", int'(dut.state), ST_IDLE);
        check("midrst_idx", int'(dut.idx_reg), 0);
        $display("midrun reset: classifier=%b state=%0d", classifier, int'(dut.state));
        @(negedge clk);
        rst = 1'b1;
        prev_cls = 0;
        build_beat(10, 7, 40);
        run_beat("after_rst", 1, 40, 7, 10, 1'b0);

        // start held high: results at E+16 and E+34.
        beat = '{8'd16, 8'd15, 8'd7, 8'd3, 8'd0, 8'd3, 8'd5, 8'd6,
                 8'd6, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
        @(negedge clk);
        for (int k = 0; k < 15; k++) ecg_input[k] = beat[k];
        start = 1'b1;
        @(posedge clk);                       // E
        repeat (16) @(posedge clk);           // E+16
        #1;
        check("cont_cls1", int'(classifier), 2);
        build_beat(10, 7, 200);
        for (int k = 0; k < 15; k++) ecg_input[k] = beat[k];
        @(posedge clk);                       // E+17
        #1;
        check("cont_idle", int'(dut.state), ST_IDLE);
        @(posedge clk);                       // E+18
        #1;
        check("cont_rescan", int'(dut.state), ST_SCAN);
        repeat (15) @(posedge clk);           // E+33
        #1;
        check("cont_held", int'(classifier), 2);
        @(posedge clk);                       // E+34
        #1;
        check("cont_cls2", int'(classifier), 4);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("cont_end_state", int'(dut.state), ST_IDLE);
        $display("continuous start: classifier=%b", classifier);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
